// File: rtl/div_unit_pkg.sv
// Shared CPU package slice: divider state encoding and default operand width.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and shift the result bit into the quotient.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] prem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dsor,
  output logic [WIDTH-1:0] prem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH:0]   shifted_s;
  logic [WIDTH-1:0] diff_s;

  // compare-and-restore: the difference fits in WIDTH bits whenever it is taken
  always_comb begin
    shifted_s = {prem, quo[WIDTH-1]};
    diff_s    = shifted_s[WIDTH-1:0] - dsor;
    if (shifted_s >= {1'b0, dsor}) begin
      prem_nxt = diff_s;
      quo_nxt  = {quo[WIDTH-2:0], 1'b1};
    end else begin
      prem_nxt = shifted_s[WIDTH-1:0];
      quo_nxt  = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider (DIV/DIVU): magnitudes are divided over WIDTH steps,
// then a single FIX cycle applies sign correction and the divide-by-zero result.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int               CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    logic [WIDTH-1:0] res;
    if (neg) res = ~v + ONE_W;
    else     res = v;
    return res;
  endfunction

  div_state_e       state_r, state_nxt_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] prem_r, quo_r, dsor_r;
  logic [WIDTH-1:0] prem_nxt_s, quo_nxt_s;
  logic             neg_q_r, neg_rem_r;
  logic             busy_r, done_r, div_zero_r;
  logic [WIDTH-1:0] quotient_r, remainder_r;
  logic             accept_s;

  assign accept_s = start && ((state_r == S_IDLE) || (state_r == S_DONE));

  div_step #(.WIDTH(WIDTH)) u_step (
    .prem     (prem_r),
    .quo      (quo_r),
    .dsor     (dsor_r),
    .prem_nxt (prem_nxt_s),
    .quo_nxt  (quo_nxt_s)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_nxt_s;
  end

  // next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE:  if (accept_s) state_nxt_s = S_RUN;  else state_nxt_s = S_IDLE;
      S_RUN:   if (cnt_r == CNT_LAST) state_nxt_s = S_FIX; else state_nxt_s = S_RUN;
      S_FIX:   state_nxt_s = S_DONE;
      S_DONE:  if (accept_s) state_nxt_s = S_RUN;  else state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // operand capture, iteration datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r       <= {CW{1'b0}};
      prem_r      <= ZERO_W;
      quo_r       <= ZERO_W;
      dsor_r      <= ZERO_W;
      neg_q_r     <= 1'b0;
      neg_rem_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      div_zero_r  <= 1'b0;
      quotient_r  <= ZERO_W;
      remainder_r <= ZERO_W;
    end else begin
      busy_r <= (state_nxt_s == S_RUN) || (state_nxt_s == S_FIX);
      done_r <= (state_r == S_FIX);
      if (accept_s) begin
        cnt_r     <= {CW{1'b0}};
        prem_r    <= ZERO_W;
        quo_r     <= cond_neg(dividend, is_signed & dividend[WIDTH-1]);
        dsor_r    <= cond_neg(divisor, is_signed & divisor[WIDTH-1]);
        neg_q_r   <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        neg_rem_r <= is_signed & dividend[WIDTH-1];
      end else if (state_r == S_RUN) begin
        cnt_r  <= cnt_r + CNT_ONE;
        prem_r <= prem_nxt_s;
        quo_r  <= quo_nxt_s;
      end
      // with a zero divisor every step subtracts nothing, so prem_r ends as |dividend|
      if (state_r == S_FIX) begin
        div_zero_r  <= (dsor_r == ZERO_W);
        remainder_r <= cond_neg(prem_r, neg_rem_r);
        if (dsor_r == ZERO_W) quotient_r <= {WIDTH{1'b1}};
        else                  quotient_r <= cond_neg(quo_r, neg_q_r);
      end
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign quotient  = quotient_r;
  assign remainder = remainder_r;
  assign div_zero  = div_zero_r;

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand and result width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  request a divide; sampled only when busy=0.
REQ-005 SHALL have port: is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
REQ-006 SHALL have port: dividend  input  WIDTH  numerator; sampled with start.
REQ-007 SHALL have port: divisor  input  WIDTH  denominator; sampled with start.
REQ-008 SHALL have port: busy  output  1  high while a divide is in progress.
REQ-009 SHALL have port: done  output  1  one-cycle pulse marking quotient/remainder valid.
REQ-010 SHALL have port: quotient  output  WIDTH  result, to the LO writeback select input.
REQ-011 SHALL have port: remainder  output  WIDTH  result, to the HI writeback select input.
REQ-012 SHALL have port: div_zero  output  1  registered flag, divisor was zero for the last accepted operation.

Function
REQ-013 SHALL implement states IDLE, RUN, FIX and DONE.
REQ-014 SHALL accept start at a rising edge only in IDLE or DONE; accepted edge = k; transition to RUN, iteration counter = 0.
REQ-015 SHALL ignore start while busy=1 (RUN or FIX), with no effect on operands or state.
REQ-016 SHALL latch magnitudes |dividend|, |divisor| on accept when is_signed=1, raw values otherwise, plus both operand signs.
REQ-017 SHALL perform one restoring shift-subtract step per edge k+1..k+WIDTH and enter FIX at edge k+WIDTH.
REQ-018 SHALL, at edge k+WIDTH+1, apply sign correction and register quotient/remainder, then enter DONE.
REQ-019 SHALL drive done=1 for exactly the cycle after edge k+WIDTH+1 (latency WIDTH+1 edges, 33 at default); DONE returns to IDLE next edge unless start is present.
REQ-020 SHALL drive busy=1 in RUN and FIX only; busy=0 in IDLE and DONE.
REQ-021 SHALL, in signed mode, truncate the quotient toward zero: quotient negative iff operand signs differ; remainder takes the dividend's sign.
REQ-022 SHALL, for divisor=0, complete with the normal latency: quotient = all ones, remainder = dividend (unmodified), div_zero=1, in both modes.
REQ-023 SHALL, for signed 0x80000000 / 0xFFFFFFFF, give quotient 0x80000000 and remainder 0 with no flag.
REQ-024 SHALL hold quotient, remainder and div_zero stable from done until the next accepted start's FIX edge.
REQ-025 SHALL, on start accepted in DONE, show done=0 in the following cycle.

Reset
REQ-026 SHALL, on rst_n=0 (asynchronous, any state, including mid-RUN), force IDLE, counter 0, busy=0, done=0, quotient=0, remainder=0, div_zero=0.
REQ-027 SHALL accept no start until the first rising edge after rst_n deasserts; any aborted operation produces no done.

Structure
REQ-028 SHALL place the state encoding (IDLE/RUN/FIX/DONE) and default WIDTH constant in the shared CPU package.
REQ-029 SHALL contain one sub-module, div_step: combinational single restoring step, (partial remainder, quotient, divisor) -> (next partial remainder, next quotient).
REQ-030 SHALL contain no combinational path from the inputs to any output.

Verification
REQ-031 SHALL cover unsigned 100 / 7 -> after 33 edges: done pulse, quotient 14, remainder 2, div_zero 0.
REQ-032 SHALL cover signed -7 / 2 (0xFFFFFFF9 / 2) -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1).
REQ-033 SHALL cover unsigned 0x12345678 / 0 -> quotient 0xFFFFFFFF, remainder 0x12345678, div_zero 1, latency 33.
REQ-034 SHALL cover signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; also start re-pulsed mid-RUN -> ignored, results unchanged.
REQ-035 SHALL cover rst_n low at edge k+10 of a divide -> outputs 0 immediately, no done; then a new 9 / 3 -> quotient 3, remainder 0.
REQ-036 SHALL cover back-to-back start in DONE cycle -> second result valid exactly 33 edges later, done low in between.
